bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Central arbiter, the responder side of the master request/grant handshake on the shared serial bus. Each master raises `b_request` and waits for `b_grant`. The arbiter grants one master at a time, round-robin. It tracks ownership through the resolved `b_bus_utilizing` line and reclaims the bus on release, or on timeout if the granted master never starts. It also drives the arbiter contribution to `slv_bsy` so slaves stay quiet during grant handover.

Parameters:
- `NUM_MASTERS`, 4, number of requesting masters (2..8).
- `MID_WIDTH`, 2, width of the master index; must be at least ceil(log2(`NUM_MASTERS`)).
- `TIMEOUT_LEN`, 6, width in bits of the grant-acceptance timeout counter; the window is 2^`TIMEOUT_LEN` clocks.
- `MAX_TXN_LEN`, 10, width in bits of the watchdog counter; used only when the optional feature is compiled in.

Ports:
- `clk`, input, 1, system clock.
- `rstn`, input, 1, reset; synchronous, active-low.
- `b_request`, input, `NUM_MASTERS`, per-master request; bit i belongs to master i.
- `b_grant`, output, `NUM_MASTERS`, per-master grant; one-hot or zero.
- `b_bus_utilizing`, input, 1, resolved bus-utilizing line; high while the owner is transacting.
- `arb_slv_bsy`, output, 1, arbiter drive for `slv_bsy`; the top level tri-states it when low.
- `arb_owner`, output, `MID_WIDTH`, index of the current or last granted master.
- `arb_bus_bsy`, output, 1, high in GRANT, BUSY and RELEASE.
- `arb_timeout`, output, 1, one-cycle pulse when a grant is revoked.

Behaviour:
- Reset (`rstn` low at a clk edge):
  - state becomes IDLE.
  - `b_grant`, `arb_slv_bsy`, `arb_bus_bsy` and `arb_timeout` become 0.
  - `arb_owner` becomes 0, and the round-robin pointer becomes 0.
  - Counters clear.
  - This applies mid-transaction too: all grants drop at that edge with no RELEASE cycle.
- Inputs are sampled at the rising edge. All outputs are registered.
- Round-robin pick: search starts at (pointer), wraps modulo `NUM_MASTERS`, and takes the first set request bit. After each grant ends, pointer becomes (owner+1) modulo `NUM_MASTERS`.
- IDLE:
  - If any request is set, latch the winner into `arb_owner`.
  - Next cycle: `b_grant[winner]`=1, `arb_bus_bsy`=1, `arb_slv_bsy`=1, state becomes GRANT. Request-to-grant latency is 1 clock.
- GRANT:
  - The timeout counter increments each cycle.
  - If `b_bus_utilizing` is sampled 1: clear the counter, set `arb_slv_bsy`=0 (the master owns the bus), go to BUSY.
  - If the owner's request drops before utilizing rises: go to RELEASE, no timeout pulse.
  - If the counter reaches 2^`TIMEOUT_LEN`-1 with utilizing still 0: `arb_timeout`=1 for one cycle, go to RELEASE.
  - If utilizing rises in the same cycle as the counter saturates, utilizing wins and the state goes to BUSY.
- BUSY:
  - Grant is held.
  - When `b_bus_utilizing` falls: go to RELEASE.
  - Requests from other masters are ignored; no preemption.
- RELEASE:
  - Exactly one dead cycle.
  - `b_grant`=0 and `arb_slv_bsy`=1.
  - Pointer advances.
  - Then go to IDLE; `arb_slv_bsy` and `arb_bus_bsy` become 0 on entry to IDLE.
  - The released master's request is not considered in the RELEASE cycle.
- Back-to-back: request-to-request turnaround is RELEASE + IDLE + grant, i.e. the next grant appears 2 clocks after utilizing falls.
- `b_request` bits for indices at or above `NUM_MASTERS` do not exist. `arb_owner` never exceeds `NUM_MASTERS`-1.
- If `b_bus_utilizing` is high while in IDLE (a rogue master), no grant is issued until it falls.

Optional Feature:
- Macro: `ARB_WATCHDOG_EN`.
- Defined: a BUSY-state counter of `MAX_TXN_LEN` bits runs. At 2^`MAX_TXN_LEN`-1 cycles with utilizing still high:
  - force `b_grant`=0 and pulse `arb_timeout`.
  - go to RELEASE, then IDLE.
  - IDLE still waits for utilizing to fall before the next grant.
- Not defined: BUSY waits indefinitely and no watchdog counter logic exists.

Decomposition:
- Shared bus definitions header holds:
  - state encodings: IDLE=2'd0, GRANT=2'd1, BUSY=2'd2, RELEASE=2'd3.
  - default `TIMEOUT_LEN`=6.
  - the grant-width helper constant.
- One sub-module is natural: `rr_picker`. It is combinational: inputs are the request vector and pointer; outputs are a valid flag and the winner index.

Test Plan:
- Single request: reset, then `b_request`=4'b0100 → `b_grant`=4'b0100 one clock later, `arb_owner`=2. Utilizing high for 20 clocks then low → grant drops on the next edge, with exactly 1 RELEASE cycle.
- Round-robin: `b_request`=4'b1011 held, each master transacts 5 clocks → grant order 0, 1, 3, 0.
- Timeout: grant master 1, utilizing never rises → `arb_timeout` pulses at clock 63 after grant, grant drops, pointer becomes 2.
- Request withdrawn in GRANT: master 0 drops request at clock 3 → RELEASE, no timeout pulse, IDLE after 1 clock.
- Reset mid-BUSY: `rstn` low while owner=3 → `b_grant`=0, `arb_slv_bsy`=0, `arb_owner`=0 at that edge. After release, `b_request`=4'b1001 → master 0 granted.
- With `ARB_WATCHDOG_EN` and `MAX_TXN_LEN`=4: utilizing stuck high → grant revoked after 15 BUSY clocks, `arb_timeout` pulses, no new grant until utilizing falls.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding and defaults.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int DEFAULT_NUM_MASTERS = 4;   // grant vector width
    localparam int DEFAULT_TIMEOUT_LEN = 6;
    localparam int DEFAULT_MAX_TXN_LEN = 10;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
import bus_arbiter_pkg::*;

module bus_arbiter_rr_picker #(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int MID_WIDTH   = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MID_WIDTH-1:0]   ptr,
    output logic                   valid,
    output logic [MID_WIDTH-1:0]   winner
);

    int win;

    // Walk offsets from the far end back to ptr so the nearest set bit wins.
    always_comb begin
        win = 0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (req[j] && (j == ((int'(ptr) + i) % NUM_MASTERS))) begin
                    win = j;
                end
            end
        end
    end

    assign valid  = |req;
    assign winner = MID_WIDTH'(win);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with grant timeout; define ARB_WATCHDOG_EN to add a
// BUSY-state watchdog that revokes a grant held for 2^MAX_TXN_LEN-1 cycles.
import bus_arbiter_pkg::*;

module bus_arbiter #(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int MID_WIDTH   = 2,
    parameter int TIMEOUT_LEN = DEFAULT_TIMEOUT_LEN,
    parameter int MAX_TXN_LEN = DEFAULT_MAX_TXN_LEN
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] b_request,
    output logic [NUM_MASTERS-1:0] b_grant,
    input  logic                   b_bus_utilizing,
    output logic                   arb_slv_bsy,
    output logic [MID_WIDTH-1:0]   arb_owner,
    output logic                   arb_bus_bsy,
    output logic                   arb_timeout
);

    arb_state_e               state_reg, state_next;
    logic [NUM_MASTERS-1:0]   grant_reg, grant_next;
    logic [MID_WIDTH-1:0]     owner_reg, owner_next;
    logic [MID_WIDTH-1:0]     ptr_reg, ptr_next;
    logic                     slv_bsy_reg, slv_bsy_next;
    logic                     bus_bsy_reg, bus_bsy_next;
    logic                     timeout_reg, timeout_next;
    logic [TIMEOUT_LEN-1:0]   tcnt_reg, tcnt_next;
`ifdef ARB_WATCHDOG_EN
    logic [MAX_TXN_LEN-1:0]   wcnt_reg, wcnt_next;
`endif

    logic                     pick_valid;
    logic [MID_WIDTH-1:0]     pick_winner;
    logic [NUM_MASTERS-1:0]   pick_onehot;
    logic                     owner_req;

    bus_arbiter_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MID_WIDTH   (MID_WIDTH)
    ) u_rr_picker (
        .req    (b_request),
        .ptr    (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_winner == MID_WIDTH'(gi));
        end
    endgenerate

    // grant_reg is one-hot on the owner while granted, so this is the owner's request.
    assign owner_req = |(b_request & grant_reg);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            slv_bsy_reg <= 1'b0;
            bus_bsy_reg <= 1'b0;
            timeout_reg <= 1'b0;
            tcnt_reg    <= '0;
`ifdef ARB_WATCHDOG_EN
            wcnt_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            slv_bsy_reg <= slv_bsy_next;
            bus_bsy_reg <= bus_bsy_next;
            timeout_reg <= timeout_next;
            tcnt_reg    <= tcnt_next;
`ifdef ARB_WATCHDOG_EN
            wcnt_reg    <= wcnt_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        slv_bsy_next = slv_bsy_reg;
        bus_bsy_next = bus_bsy_reg;
        timeout_next = 1'b0;
        tcnt_next    = tcnt_reg;
`ifdef ARB_WATCHDOG_EN
        wcnt_next    = wcnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                // A rogue master still driving utilizing blocks any new grant.
                if (pick_valid && !b_bus_utilizing) begin
                    owner_next   = pick_winner;
                    grant_next   = pick_onehot;
                    bus_bsy_next = 1'b1;
                    slv_bsy_next = 1'b1;
                    tcnt_next    = '0;
                    state_next   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                tcnt_next = tcnt_reg + TIMEOUT_LEN'(1);
                if (b_bus_utilizing) begin
                    tcnt_next    = '0;
                    slv_bsy_next = 1'b0;
                    state_next   = ST_BUSY;
`ifdef ARB_WATCHDOG_EN
                    wcnt_next    = '0;
`endif
                end else if (!owner_req) begin
                    grant_next   = '0;
                    state_next   = ST_RELEASE;
                end else if (tcnt_next == '1) begin
                    grant_next   = '0;
                    timeout_next = 1'b1;
                    state_next   = ST_RELEASE;
                end
            end
            ST_BUSY: begin
                if (!b_bus_utilizing) begin
                    grant_next   = '0;
                    slv_bsy_next = 1'b1;
                    state_next   = ST_RELEASE;
                end
`ifdef ARB_WATCHDOG_EN
                else begin
                    wcnt_next = wcnt_reg + MAX_TXN_LEN'(1);
                    if (wcnt_next == '1) begin
                        grant_next   = '0;
                        slv_bsy_next = 1'b1;
                        timeout_next = 1'b1;
                        state_next   = ST_RELEASE;
                    end
                end
`endif
            end
            ST_RELEASE: begin
                ptr_next     = MID_WIDTH'((int'(owner_reg) + 1) % NUM_MASTERS);
                grant_next   = '0;
                slv_bsy_next = 1'b0;
                bus_bsy_next = 1'b0;
                state_next   = ST_IDLE;
            end
            default: begin
                grant_next   = '0;
                slv_bsy_next = 1'b0;
                bus_bsy_next = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    assign b_grant     = grant_reg;
    assign arb_owner   = owner_reg;
    assign arb_slv_bsy = slv_bsy_reg;
    assign arb_bus_bsy = bus_bsy_reg;
    assign arb_timeout = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios plus randomized rounds.
module tb_bus_arbiter;

    localparam int N = 4;

    logic       clk;
    logic       rstn;
    logic [N-1:0] b_request;
    logic [N-1:0] b_grant;
    logic       b_bus_utilizing;
    logic       arb_slv_bsy;
    logic [1:0] arb_owner;
    logic       arb_bus_bsy;
    logic       arb_timeout;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mptr;
    logic [N-1:0] prev_grant = '0;
    int mon_e;

    bus_arbiter #(
        .NUM_MASTERS (N),
        .MID_WIDTH   (2),
        .TIMEOUT_LEN (6),
        .MAX_TXN_LEN (4)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .b_request       (b_request),
        .b_grant         (b_grant),
        .b_bus_utilizing (b_bus_utilizing),
        .arb_slv_bsy     (arb_slv_bsy),
        .arb_owner       (arb_owner),
        .arb_bus_bsy     (arb_bus_bsy),
        .arb_timeout     (arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference round-robin: first requester at or after ptr, modulo N.
    function automatic int rr_model(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rstn && b_grant != '0 && prev_grant == '0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected actual=%b required=none", b_grant);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_grant", 32'(b_grant), 32'(1) << mon_e);
                chk("sb_owner", 32'(arb_owner), 32'(mon_e));
                $display("txn grant master=%0d vec=%b", mon_e, b_grant);
            end
        end
        prev_grant = b_grant;
    end

    task automatic do_reset();
        rstn = 1'b0;
        b_request = '0;
        b_bus_utilizing = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        mptr = 0;
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        @(negedge clk);
        while (b_grant == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (b_grant == '0) chk({name, "_grant_wait"}, 32'(n), 32'(0));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((arb_bus_bsy || b_grant != '0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (arb_bus_bsy) chk({name, "_idle_wait"}, 32'(n), 32'(0));
    endtask

    task automatic issue(input logic [N-1:0] req);
        exp_q.push_back(rr_model(req, mptr));
        b_request = req;
    endtask

    task automatic transact(input int len);
        b_bus_utilizing = 1'b1;
        repeat (len) @(negedge clk);
        b_bus_utilizing = 1'b0;
        mptr = (int'(arb_owner) + 1) % N;
        @(negedge clk);
        wait_idle("txn");
    endtask

    initial begin
        int n;
        int w;
        int mode;
        int k;
        int order[4] = '{0, 1, 3, 0};
        logic [N-1:0] r;

        do_reset();
        chk("rst_grant", 32'(b_grant), 0);
        chk("rst_slv", 32'(arb_slv_bsy), 0);
        chk("rst_bus", 32'(arb_bus_bsy), 0);
        chk("rst_to", 32'(arb_timeout), 0);
        chk("rst_owner", 32'(arb_owner), 0);

        // single request with 1-clock latency and a single RELEASE cycle
        issue(4'b0100);
        @(negedge clk);
        chk("single_grant", 32'(b_grant), 32'h4);
        chk("single_owner", 32'(arb_owner), 2);
        chk("single_bus", 32'(arb_bus_bsy), 1);
        chk("single_slv_grant", 32'(arb_slv_bsy), 1);
        b_bus_utilizing = 1'b1;
        repeat (20) @(negedge clk);
        chk("single_slv_busy", 32'(arb_slv_bsy), 0);
        b_bus_utilizing = 1'b0;
        @(negedge clk);
        chk("rel_grant", 32'(b_grant), 0);
        chk("rel_bus", 32'(arb_bus_bsy), 1);
        chk("rel_slv", 32'(arb_slv_bsy), 1);
        b_request = '0;
        @(negedge clk);
        chk("idle_bus", 32'(arb_bus_bsy), 0);
        chk("idle_slv", 32'(arb_slv_bsy), 0);
        mptr = 3;

        // round-robin order from reset with 1011 held
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(4'b1011);
            wait_grant("rr");
            chk("rr_order", 32'(arb_owner), 32'(order[i]));
            transact(5);
        end
        b_request = '0;
        @(negedge clk);

        // grant timeout after 63 clocks, pointer moves past master 1
        do_reset();
        issue(4'b0010);
        wait_grant("to");
        n = 0;
        while (!arb_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 63);
        chk("to_grant", 32'(b_grant), 0);
        @(negedge clk);
        chk("to_pulse_width", 32'(arb_timeout), 0);
        mptr = 2;
        wait_idle("to");
        issue(4'b0111);
        wait_grant("to_next");
        b_request = '0;
        mptr = 3;
        @(negedge clk);
        wait_idle("to_next");

        // request withdrawn during GRANT
        do_reset();
        issue(4'b0001);
        wait_grant("wd");
        repeat (2) @(negedge clk);
        b_request = '0;
        @(negedge clk);
        chk("wd_grant", 32'(b_grant), 0);
        chk("wd_to", 32'(arb_timeout), 0);
        chk("wd_bus", 32'(arb_bus_bsy), 1);
        @(negedge clk);
        chk("wd_idle", 32'(arb_bus_bsy), 0);

        // reset in the middle of a BUSY transaction owned by master 3
        do_reset();
        issue(4'b1000);
        wait_grant("mr");
        b_bus_utilizing = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_grant", 32'(b_grant), 0);
        chk("mr_slv", 32'(arb_slv_bsy), 0);
        chk("mr_owner", 32'(arb_owner), 0);
        chk("mr_bus", 32'(arb_bus_bsy), 0);
        rstn = 1'b1;
        b_bus_utilizing = 1'b0;
        b_request = '0;
        mptr = 0;
        @(negedge clk);
        issue(4'b1001);
        wait_grant("mr_next");
        chk("mr_next_owner", 32'(arb_owner), 0);
        transact(2);
        b_request = '0;

        // rogue utilizing in IDLE blocks grants
        b_bus_utilizing = 1'b1;
        issue(4'b0100);
        repeat (10) @(negedge clk);
        chk("rogue_block", 32'(b_grant), 0);
        b_bus_utilizing = 1'b0;
        wait_grant("rogue");
        b_request = '0;
        mptr = 3;
        @(negedge clk);
        wait_idle("rogue");

`ifdef ARB_WATCHDOG_EN
        issue(4'b0001);
        wait_grant("wdog");
        b_bus_utilizing = 1'b1;
        @(negedge clk);
        chk("wdog_busy", 32'(arb_slv_bsy), 0);
        n = 0;
        while (!arb_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_cycles", 32'(n), 15);
        chk("wdog_grant", 32'(b_grant), 0);
        mptr = 1;
        repeat (10) @(negedge clk);
        chk("wdog_hold", 32'(b_grant), 0);
        issue(4'b0001);
        b_bus_utilizing = 1'b0;
        wait_grant("wdog_next");
        b_request = '0;
        mptr = 1;
        @(negedge clk);
        wait_idle("wdog_next");
`endif

        // randomized rounds against the round-robin model
        for (int t = 0; t < 30; t++) begin
            r = N'($urandom_range(1, 15));
            issue(r);
            wait_grant("rnd");
            w = int'(arb_owner);
            mode = $urandom_range(0, 2);
            k = $urandom_range(0, 4);
            repeat (k) @(negedge clk);
            if (mode == 0) begin
                b_request[w] = 1'b0;
                @(negedge clk);
                chk("rnd_wd_grant", 32'(b_grant), 0);
                chk("rnd_wd_to", 32'(arb_timeout), 0);
                mptr = (w + 1) % N;
                wait_idle("rnd_wd");
            end else begin
                transact($urandom_range(1, 8));
            end
        end
        b_request = '0;

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
